hilo_div_unit: RTL and testbench

- Owns the architectural HI/LO register pair for the execute stage.
- Supplies HI/LO to the ALU read ports (hi_in, lo_in) and accepts ALU writes from mult/multu/mthi/mtlo.
- Contains an iterative radix-2 divider for div/divu, which writes quotient to LO and remainder to HI.
- Asserts a combinational stall while a divide is in progress.

---
 rtl/hilo_div_unit_pkg.sv | 25 ++
 rtl/hilo_div_unit_if.sv | 36 +++
 rtl/hilo_div_unit_div_core.sv | 53 +++++
 rtl/hilo_div_unit.sv | 90 +++++++++
 tb/tb_hilo_div_unit.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/hilo_div_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hilo_pkg
// Description : Shared FSM encodings, divider constants and sign helper for
//               the HI/LO register and divider unit.
// Revision    : 1.0 - initial release
// ============================================================================
package hilo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } hilo_state_e;

    localparam int DIV_ITERS = 32;
    localparam int CNT_W     = 6;

    // Conditional two's-complement negate used by the sign fix-up.
    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_div_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : hilo_div_unit_if
// Description : Execute-stage bus between the pipeline and the HI/LO unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface hilo_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] hi_wdata;
    logic [WIDTH-1:0] lo_wdata;
    logic             div_start;
    logic             div_signed;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             flush;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             div_busy;
    logic             div_done;

    modport master (
        output hi_we, lo_we, hi_wdata, lo_wdata,
        output div_start, div_signed, div_a, div_b, flush,
        input  hi_o, lo_o, div_busy, div_done
    );

    modport slave (
        input  hi_we, lo_we, hi_wdata, lo_wdata,
        input  div_start, div_signed, div_a, div_b, flush,
        output hi_o, lo_o, div_busy, div_done
    );
endinterface
`default_nettype wire

// File: rtl/hilo_div_unit_div_core.sv
`default_nettype none
// ============================================================================
// Module      : div_core
// Description : Unsigned restoring divider datapath, one quotient bit per step.
// Revision    : 1.0 - initial release
// ============================================================================
module div_core #(
    parameter int WIDTH = 32
) (
    input  wire logic             clk,
    input  wire logic             resetn,
    input  wire logic             load_i,
    input  wire logic             step_i,
    input  wire logic [WIDTH-1:0] dividend_i,
    input  wire logic [WIDTH-1:0] divisor_i,
    output logic      [WIDTH-1:0] quo_nx_o,
    output logic      [WIDTH-1:0] rem_nx_o
);
    logic [WIDTH-1:0] rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0] rem_d, quo_d;
    logic [WIDTH:0]   shift_w;
    logic [WIDTH+1:0] trial_w;
    logic             fits_w;

    // Shifted partial remainder can reach WIDTH+1 bits, so the trial carries
    // one extra guard bit to keep its sign unambiguous for large divisors.
    always_comb begin
        shift_w = {rem_q, quo_q[WIDTH-1]};
        trial_w = {1'b0, shift_w} - {2'b00, dvs_q};
        fits_w  = ~trial_w[WIDTH+1];
        rem_d   = fits_w ? trial_w[WIDTH-1:0] : shift_w[WIDTH-1:0];
        quo_d   = {quo_q[WIDTH-2:0], fits_w};
    end

    assign quo_nx_o = quo_d;
    assign rem_nx_o = rem_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load_i) begin
            rem_q <= '0;
            quo_q <= dividend_i;
            dvs_q <= divisor_i;
        end else if (step_i) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
        end
    end
endmodule
`default_nettype wire

// File: rtl/hilo_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : hilo_div_unit
// Description : Architectural HI/LO registers with direct writes and an
//               iterative signed/unsigned divider that stalls the pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module hilo_div_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic       clk,
    input  wire logic       resetn,
    hilo_div_unit_if.slave  bus
);
    hilo_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             sign_q_q, sign_r_q, done_q;
    logic [WIDTH-1:0] hi_q, lo_q;
    logic [WIDTH-1:0] mag_a_w, mag_b_w, quo_nx_w, rem_nx_w;
    logic             accept_w, last_w;

    assign accept_w = (state_q == IDLE) & bus.div_start & ~bus.flush;
    assign last_w   = (state_q == RUN) & ~bus.flush
                    & (cnt_q == CNT_W'(DIV_ITERS - 1));
    assign mag_a_w  = neg_if(bus.div_signed & bus.div_a[WIDTH-1], bus.div_a);
    assign mag_b_w  = neg_if(bus.div_signed & bus.div_b[WIDTH-1], bus.div_b);

    div_core #(.WIDTH(WIDTH)) u_core (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     (accept_w),
        .step_i     (state_q == RUN),
        .dividend_i (mag_a_w),
        .divisor_i  (mag_b_w),
        .quo_nx_o   (quo_nx_w),
        .rem_nx_o   (rem_nx_w)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sign_q_q <= 1'b0;
            sign_r_q <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept_w) begin
                        state_q  <= RUN;
                        cnt_q    <= '0;
                        sign_q_q <= bus.div_signed & (bus.div_a[WIDTH-1] ^ bus.div_b[WIDTH-1]);
                        sign_r_q <= bus.div_signed & bus.div_a[WIDTH-1];
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state_q <= IDLE;
                    end else if (last_w) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase

            // Divider result takes priority over a same-edge ALU write.
            if (last_w) begin
                hi_q <= neg_if(sign_r_q, rem_nx_w);
                lo_q <= neg_if(sign_q_q, quo_nx_w);
            end else begin
                if (bus.hi_we) hi_q <= bus.hi_wdata;
                if (bus.lo_we) lo_q <= bus.lo_wdata;
            end
        end
    end

    assign bus.hi_o     = hi_q;
    assign bus.lo_o     = lo_q;
    assign bus.div_done = done_q;
    assign bus.div_busy = (state_q == RUN) | accept_w;
endmodule
`default_nettype wire

// File: tb/tb_hilo_div_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hilo_div_unit
// Description : Directed vector bench for the HI/LO register and divider unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hilo_div_unit;
    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    hilo_div_unit_if #(.WIDTH(32)) bus ();

    hilo_div_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        string       name;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits a bounded number of cycles and reports whether div_done ever rose.
    task automatic watch_no_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.div_done === 1'b1) seen = 1'b1;
            tick();
        end
        check(name, {31'd0, seen}, 32'd0);
    endtask

    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input string nm);
        int   n;
        logic busy_ok;
        bus.div_signed = sgn;
        bus.div_a      = a;
        bus.div_b      = b;
        bus.div_start  = 1'b1;
        #1;
        check({nm, "_busy_at_start"}, {31'd0, bus.div_busy}, 32'd1);
        tick();
        bus.div_start = 1'b0;
        n       = 0;
        busy_ok = 1'b1;
        while (bus.div_done !== 1'b1 && n < 40) begin
            if (bus.div_busy !== 1'b1) busy_ok = 1'b0;
            tick();
            n++;
        end
        check({nm, "_latency"}, n, 32'd32);
        check({nm, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
        check({nm, "_lo"}, bus.lo_o, exp_lo);
        check({nm, "_hi"}, bus.hi_o, exp_hi);
        check({nm, "_busy_done"}, {31'd0, bus.div_busy}, 32'd0);
        tick();
        check({nm, "_done_pulse"}, {31'd0, bus.div_done}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         "divu_100_7"};
        vecs[1] = '{1'b1, 32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF,  "div_m7_2"};
        vecs[2] = '{1'b1, 32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1,         "div_7_m2"};
        vecs[3] = '{1'b0, 32'h1234,      32'd0,         32'hFFFFFFFF,  32'h1234,      "divu_by0"};
        vecs[4] = '{1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0,         "div_ovf"};
        vecs[5] = '{1'b0, 32'hFFFFFFFF,  32'h00010000,  32'h0000FFFF,  32'h0000FFFF,  "divu_max"};
        vecs[6] = '{1'b0, 32'hFFFFFFFF,  32'h80000001,  32'd1,         32'h7FFFFFFE,  "divu_bigdiv"};
        vecs[7] = '{1'b1, 32'h80000000,  32'd0,         32'd1,         32'h80000000,  "div_min_by0"};
        vecs[8] = '{1'b1, 32'hFFFFFF9C,  32'hFFFFFFF9,  32'd14,        32'hFFFFFFFE,  "div_m100_m7"};

        resetn         = 1'b0;
        bus.hi_we      = 1'b0;
        bus.lo_we      = 1'b0;
        bus.hi_wdata   = '0;
        bus.lo_wdata   = '0;
        bus.div_start  = 1'b0;
        bus.div_signed = 1'b0;
        bus.div_a      = '0;
        bus.div_b      = '0;
        bus.flush      = 1'b0;
        tick();
        tick();
        check("rst_hi", bus.hi_o, 32'd0);
        check("rst_lo", bus.lo_o, 32'd0);
        check("rst_done", {31'd0, bus.div_done}, 32'd0);
        check("rst_busy", {31'd0, bus.div_busy}, 32'd0);
        resetn = 1'b1;
        tick();

        // Independent HI write, then mult-style dual write.
        bus.hi_we = 1'b1; bus.hi_wdata = 32'hDEAD; bus.lo_wdata = 32'hBEEF;
        tick();
        bus.hi_we = 1'b0;
        check("mthi_hi", bus.hi_o, 32'hDEAD);
        check("mthi_lo", bus.lo_o, 32'd0);
        bus.hi_we = 1'b1; bus.lo_we = 1'b1;
        bus.hi_wdata = 32'h11111111; bus.lo_wdata = 32'h22222222;
        tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        check("mult_hi", bus.hi_o, 32'h11111111);
        check("mult_lo", bus.lo_o, 32'h22222222);

        for (int i = 0; i < 9; i++)
            run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].name);

        // Flush at iteration 10 with preloaded HI/LO.
        bus.hi_we = 1'b1; bus.lo_we = 1'b1;
        bus.hi_wdata = 32'hAAAA; bus.lo_wdata = 32'h5555;
        tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        bus.div_signed = 1'b0; bus.div_a = 32'd100; bus.div_b = 32'd7; bus.div_start = 1'b1;
        tick();
        bus.div_start = 1'b0;
        repeat (10) tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_busy", {31'd0, bus.div_busy}, 32'd0);
        check("flush_done", {31'd0, bus.div_done}, 32'd0);
        check("flush_hi", bus.hi_o, 32'hAAAA);
        check("flush_lo", bus.lo_o, 32'h5555);
        watch_no_done("flush_no_done");
        check("flush_hi_later", bus.hi_o, 32'hAAAA);
        run_div(1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, "after_flush");

        // ALU writes on the completing edge lose to the divider.
        bus.div_signed = 1'b0; bus.div_a = 32'd100; bus.div_b = 32'd7; bus.div_start = 1'b1;
        tick();
        bus.div_start = 1'b0;
        repeat (31) tick();
        bus.hi_we = 1'b1; bus.hi_wdata = 32'h1111;
        bus.lo_we = 1'b1; bus.lo_wdata = 32'h2222;
        tick();
        bus.hi_we = 1'b0; bus.lo_we = 1'b0;
        check("prio_done", {31'd0, bus.div_done}, 32'd1);
        check("prio_hi", bus.hi_o, 32'd2);
        check("prio_lo", bus.lo_o, 32'd14);
        tick();

        // Reset in the middle of a divide.
        bus.div_a = 32'hFFFF; bus.div_b = 32'd3; bus.div_start = 1'b1;
        tick();
        bus.div_start = 1'b0;
        repeat (20) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        check("midrst_hi", bus.hi_o, 32'd0);
        check("midrst_lo", bus.lo_o, 32'd0);
        check("midrst_busy", {31'd0, bus.div_busy}, 32'd0);
        check("midrst_done", {31'd0, bus.div_done}, 32'd0);
        watch_no_done("midrst_no_done");

        // Start together with flush in IDLE is refused.
        bus.div_a = 32'd50; bus.div_b = 32'd5; bus.div_start = 1'b1; bus.flush = 1'b1;
        #1;
        check("sf_busy_comb", {31'd0, bus.div_busy}, 32'd0);
        tick();
        bus.div_start = 1'b0; bus.flush = 1'b0;
        #1;
        check("sf_busy_after", {31'd0, bus.div_busy}, 32'd0);
        watch_no_done("sf_no_done");
        check("sf_lo", bus.lo_o, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
